// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous memory.
// Each transaction runs IDLE -> ISSUE -> RESP; ack, data and error are registered for the following cycle.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int FAIR   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              FReq,
  input  logic [ADDR_W-1:0] FAddr,
  output logic              FAck,
  output logic [DATA_W-1:0] FData,
  output logic              FErr,
  input  logic              DReq,
  input  logic              DWE,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWData,
  output logic              DAck,
  output logic [DATA_W-1:0] DRData,
  output logic              DErr,
  input  logic              FaultClr,
  output logic              Fault,
  output logic [ADDR_W-1:0] FaultAddr,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWE,
  output logic [DATA_W-1:0] MemDIn,
  input  logic [DATA_W-1:0] MemDOut,
  input  logic              MemOOB
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state_reg, state_next;

  logic              owner_data_reg, owner_data_next;
  logic              wr_reg, wr_next;
  // Set when data should win the next contended grant; clear out of reset so fetch goes first.
  logic              data_first_reg, data_first_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              we_reg, we_next;
  logic [DATA_W-1:0] din_reg, din_next;
  logic              fack_reg, fack_next, ferr_reg, ferr_next;
  logic              dack_reg, dack_next, derr_reg, derr_next;
  logic [DATA_W-1:0] fdata_reg, fdata_next, drdata_reg, drdata_next;
  logic              fault_reg, fault_next;
  logic [ADDR_W-1:0] fault_addr_reg, fault_addr_next;
  logic              grant_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_data_next = owner_data_reg;
    wr_next         = wr_reg;
    data_first_next = data_first_reg;
    addr_next       = addr_reg;
    we_next         = 1'b0;
    din_next        = din_reg;
    fack_next       = 1'b0;
    ferr_next       = 1'b0;
    dack_next       = 1'b0;
    derr_next       = 1'b0;
    fdata_next      = fdata_reg;
    drdata_next     = drdata_reg;
    fault_next      = fault_reg;
    fault_addr_next = fault_addr_reg;
    grant_data      = 1'b0;

    if (FaultClr) begin
      fault_next      = 1'b0;
      fault_addr_next = '0;
    end

    case (state_reg)
      IDLE: begin
        if (FReq || DReq) begin
          grant_data      = DReq && (!FReq || (FAIR == 0) || data_first_reg);
          owner_data_next = grant_data;
          data_first_next = !grant_data;
          state_next      = ISSUE;
          if (grant_data) begin
            addr_next = DAddr;
            we_next   = DWE;
            wr_next   = DWE;
            din_next  = DWData;
          end else begin
            addr_next = FAddr;
            wr_next   = 1'b0;
          end
        end
      end
      ISSUE: begin
        state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
        if (owner_data_reg) begin
          dack_next = 1'b1;
          derr_next = MemOOB;
          if (!wr_reg) begin
            drdata_next = MemDOut;
          end
        end else begin
          fack_next  = 1'b1;
          ferr_next  = MemOOB;
          fdata_next = MemDOut;
        end
        // A capture coinciding with a clear re-arms with the new address.
        if (MemOOB && (!fault_reg || FaultClr)) begin
          fault_next      = 1'b1;
          fault_addr_next = addr_reg;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_data_reg <= 1'b0;
      wr_reg         <= 1'b0;
      data_first_reg <= 1'b0;
      addr_reg       <= '0;
      we_reg         <= 1'b0;
      din_reg        <= '0;
      fack_reg       <= 1'b0;
      ferr_reg       <= 1'b0;
      dack_reg       <= 1'b0;
      derr_reg       <= 1'b0;
      fdata_reg      <= '0;
      drdata_reg     <= '0;
      fault_reg      <= 1'b0;
      fault_addr_reg <= '0;
    end else begin
      owner_data_reg <= owner_data_next;
      wr_reg         <= wr_next;
      data_first_reg <= data_first_next;
      addr_reg       <= addr_next;
      we_reg         <= we_next;
      din_reg        <= din_next;
      fack_reg       <= fack_next;
      ferr_reg       <= ferr_next;
      dack_reg       <= dack_next;
      derr_reg       <= derr_next;
      fdata_reg      <= fdata_next;
      drdata_reg     <= drdata_next;
      fault_reg      <= fault_next;
      fault_addr_reg <= fault_addr_next;
    end
  end

  assign MemAddr   = addr_reg;
  assign MemWE     = we_reg;
  assign MemDIn    = din_reg;
  assign FAck      = fack_reg;
  assign FErr      = ferr_reg;
  assign FData     = fdata_reg;
  assign DAck      = dack_reg;
  assign DErr      = derr_reg;
  assign DRData    = drdata_reg;
  assign Fault     = fault_reg;
  assign FaultAddr = fault_addr_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a fair and a data-priority instance share stimulus,
// each backed by a 256-word synchronous memory that flags addresses >= 256 as out of bounds.
module tb_mem_arbiter;

  logic        clock, reset;
  logic        freq, dreq, dwe, faultclr;
  logic [15:0] faddr, daddr, dwdata;

  logic        fack1, ferr1, dack1, derr1, fault1, mwe1, moob1;
  logic [15:0] fdata1, drdata1, faultaddr1, ma1, mdi1, mdo1;
  logic        fack0, ferr0, dack0, derr0, fault0, mwe0, moob0;
  logic [15:0] fdata0, drdata0, faultaddr0, ma0, mdi0, mdo0;

  logic [15:0] mem1 [0:255];
  logic [15:0] mem0 [0:255];
  int          tests, fails, mwe_cnt;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .FAIR(1)) u_dut (
    .clock(clock), .reset(reset),
    .FReq(freq), .FAddr(faddr), .FAck(fack1), .FData(fdata1), .FErr(ferr1),
    .DReq(dreq), .DWE(dwe), .DAddr(daddr), .DWData(dwdata),
    .DAck(dack1), .DRData(drdata1), .DErr(derr1),
    .FaultClr(faultclr), .Fault(fault1), .FaultAddr(faultaddr1),
    .MemAddr(ma1), .MemWE(mwe1), .MemDIn(mdi1), .MemDOut(mdo1), .MemOOB(moob1)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .FAIR(0)) u_dut_prio (
    .clock(clock), .reset(reset),
    .FReq(freq), .FAddr(faddr), .FAck(fack0), .FData(fdata0), .FErr(ferr0),
    .DReq(dreq), .DWE(dwe), .DAddr(daddr), .DWData(dwdata),
    .DAck(dack0), .DRData(drdata0), .DErr(derr0),
    .FaultClr(faultclr), .Fault(fault0), .FaultAddr(faultaddr0),
    .MemAddr(ma0), .MemWE(mwe0), .MemDIn(mdi0), .MemDOut(mdo0), .MemOOB(moob0)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    if (mwe1 && ma1 < 16'd256) mem1[ma1[7:0]] <= mdi1;
    mdo1  <= (ma1 < 16'd256) ? mem1[ma1[7:0]] : 16'h0000;
    moob1 <= (ma1 >= 16'd256);
    if (mwe0 && ma0 < 16'd256) mem0[ma0[7:0]] <= mdi0;
    mdo0  <= (ma0 < 16'd256) ? mem0[ma0[7:0]] : 16'h0000;
    moob0 <= (ma0 >= 16'd256);
  end

  always @(negedge clock) begin
    if (mwe1) mwe_cnt <= mwe_cnt + 1;
  end

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Runs one transaction starting at a falling edge; lat = falling edges until ack, -1 on timeout.
  task automatic do_access(input bit is_d, input bit we, input logic [15:0] addr,
                           input logic [15:0] wd, output logic [15:0] rd,
                           output bit err, output int lat, output bit stray);
    lat = -1; stray = 1'b0; rd = 16'h0; err = 1'b0;
    if (is_d) begin dreq = 1'b1; dwe = we; daddr = addr; dwdata = wd; end
    else begin freq = 1'b1; faddr = addr; end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (is_d ? fack1 : dack1) stray = 1'b1;
      if (is_d ? dack1 : fack1) begin
        lat = k;
        rd  = is_d ? drdata1 : fdata1;
        err = is_d ? derr1 : ferr1;
        break;
      end
    end
    freq = 1'b0; dreq = 1'b0; dwe = 1'b0;
    $display("[TB] %s %s addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
             is_d ? "D" : "F", we ? "WR" : "RD", addr, wd, rd, err, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    tests++; if (ma1 !== 16'h0 || mdi1 !== 16'h0) begin fails++;
      $display("FAIL reset_mem addr=%h din=%h expected 0000 0000", ma1, mdi1); end
    tests++; if (mwe1 !== 1'b0) begin fails++; $display("FAIL reset_memwe got %b expected 0", mwe1); end
    tests++; if ({fack1, dack1, ferr1, derr1} !== 4'b0000) begin fails++;
      $display("FAIL reset_acks got %b expected 0000", {fack1, dack1, ferr1, derr1}); end
    tests++; if (fdata1 !== 16'h0 || drdata1 !== 16'h0) begin fails++;
      $display("FAIL reset_data f=%h d=%h expected 0000 0000", fdata1, drdata1); end
    tests++; if (fault1 !== 1'b0 || faultaddr1 !== 16'h0) begin fails++;
      $display("FAIL reset_fault got %b %h expected 0 0000", fault1, faultaddr1); end
    reset = 1'b0;
  endtask

  task automatic test_fair();
    logic [3:0] seq1, seq0;
    int n1, n0;
    apply_reset();
    seq1 = 4'h0; seq0 = 4'h0; n1 = 0; n0 = 0;
    freq = 1'b1; faddr = 16'h0004; dreq = 1'b1; dwe = 1'b0; daddr = 16'h0004;
    for (int k = 0; k < 20 && (n1 < 4 || n0 < 4); k++) begin
      @(negedge clock);
      if (fack1 || dack1) begin
        if (n1 < 4) seq1[n1] = dack1;
        $display("[TB] fair grant %0d: %s", n1, dack1 ? "D" : "F");
        n1++;
      end
      if (fack0 || dack0) begin
        if (n0 < 4) seq0[n0] = dack0;
        $display("[TB] prio grant %0d: %s", n0, dack0 ? "D" : "F");
        n0++;
      end
      if (n1 >= 4 && n0 >= 4) begin freq = 1'b0; dreq = 1'b0; end
    end
    freq = 1'b0; dreq = 1'b0;
    tests++; if (n1 !== 4 || seq1 !== 4'b1010) begin fails++;
      $display("FAIL fair_order got n=%0d seq=%b expected n=4 seq=1010 (F,D,F,D)", n1, seq1); end
    tests++; if (n0 !== 4 || seq0 !== 4'b1111) begin fails++;
      $display("FAIL prio_order got n=%0d seq=%b expected n=4 seq=1111 (D,D,D,D)", n0, seq0); end
    @(negedge clock); @(negedge clock); @(negedge clock);
  endtask

  task automatic test_fetch();
    logic [15:0] rd; bit err, stray; int lat, w0;
    apply_reset();
    w0 = mwe_cnt;
    do_access(1'b0, 1'b0, 16'h0004, 16'h0, rd, err, lat, stray);
    tests++; if (lat !== 3) begin fails++; $display("FAIL fetch_latency got %0d expected 3", lat); end
    tests++; if (rd !== 16'h1234) begin fails++; $display("FAIL fetch_data got %h expected 1234", rd); end
    tests++; if (err !== 1'b0 || stray !== 1'b0) begin fails++;
      $display("FAIL fetch_err_stray got err=%b stray=%b expected 0 0", err, stray); end
    tests++; if (mwe_cnt - w0 !== 0) begin fails++;
      $display("FAIL fetch_memwe got %0d cycles expected 0", mwe_cnt - w0); end
  endtask

  task automatic test_write_read();
    logic [15:0] rd; bit err, stray; int lat, w0;
    w0 = mwe_cnt;
    do_access(1'b1, 1'b1, 16'h0010, 16'hBEEF, rd, err, lat, stray);
    tests++; if (lat !== 3 || stray !== 1'b0) begin fails++;
      $display("FAIL write_ack got lat=%0d stray=%b expected 3 0", lat, stray); end
    tests++; if (rd !== 16'h0000) begin fails++; $display("FAIL write_drdata_held got %h expected 0000", rd); end
    tests++; if (mwe_cnt - w0 !== 1) begin fails++;
      $display("FAIL write_memwe got %0d cycles expected 1", mwe_cnt - w0); end
    do_access(1'b1, 1'b0, 16'h0010, 16'h0, rd, err, lat, stray);
    tests++; if (lat !== 3) begin fails++; $display("FAIL read_latency got %0d expected 3", lat); end
    tests++; if (rd !== 16'hBEEF) begin fails++; $display("FAIL read_back got %h expected beef", rd); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL read_err got %b expected 0", err); end
  endtask

  task automatic test_oob();
    logic [15:0] rd; bit err, stray; int lat;
    do_access(1'b1, 1'b0, 16'hFFFF, 16'h0, rd, err, lat, stray);
    tests++; if (lat !== 3 || err !== 1'b1) begin fails++;
      $display("FAIL oob_ack_err got lat=%0d err=%b expected 3 1", lat, err); end
    tests++; if (fault1 !== 1'b1 || faultaddr1 !== 16'hFFFF) begin fails++;
      $display("FAIL oob_fault got %b %h expected 1 ffff", fault1, faultaddr1); end
    do_access(1'b1, 1'b0, 16'hFFFE, 16'h0, rd, err, lat, stray);
    tests++; if (err !== 1'b1 || fault1 !== 1'b1 || faultaddr1 !== 16'hFFFF) begin fails++;
      $display("FAIL oob_keep_first got err=%b %b %h expected 1 1 ffff", err, fault1, faultaddr1); end
    faultclr = 1'b1;
    @(negedge clock);
    faultclr = 1'b0;
    tests++; if (fault1 !== 1'b0 || faultaddr1 !== 16'h0) begin fails++;
      $display("FAIL fault_clear got %b %h expected 0 0000", fault1, faultaddr1); end
  endtask

  task automatic test_clr_capture();
    logic [15:0] rd; bit err, stray; int lat;
    do_access(1'b1, 1'b0, 16'hFFFF, 16'h0, rd, err, lat, stray);
    dreq = 1'b1; dwe = 1'b0; daddr = 16'hFFF0;
    @(negedge clock);
    @(negedge clock);
    faultclr = 1'b1;
    @(negedge clock);
    faultclr = 1'b0;
    dreq = 1'b0;
    $display("[TB] D RD addr=fff0 with FaultClr at capture: dack=%b derr=%b fault=%b faultaddr=%h",
             dack1, derr1, fault1, faultaddr1);
    tests++; if (dack1 !== 1'b1 || derr1 !== 1'b1) begin fails++;
      $display("FAIL clr_capture_ack got %b %b expected 1 1", dack1, derr1); end
    tests++; if (fault1 !== 1'b1 || faultaddr1 !== 16'hFFF0) begin fails++;
      $display("FAIL clr_capture_fault got %b %h expected 1 fff0", fault1, faultaddr1); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd; bit err, stray, seen; int lat, w0;
    w0 = mwe_cnt; seen = 1'b0;
    // write to 0x0020 whose issue edge coincides with reset
    dreq = 1'b1; dwe = 1'b1; daddr = 16'h0020; dwdata = 16'hCAFE; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; dreq = 1'b0; dwe = 1'b0;
    tests++; if (mwe1 !== 1'b0) begin fails++; $display("FAIL rst_write_memwe got %b expected 0", mwe1); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (dack1 || fack1) seen = 1'b1;
    end
    $display("[TB] D WR addr=0020 wdata=cafe aborted by reset, ack_seen=%0d", seen);
    tests++; if (seen !== 1'b0 || mwe_cnt - w0 !== 0) begin fails++;
      $display("FAIL rst_write_noack got ack=%b memwe=%0d expected 0 0", seen, mwe_cnt - w0); end
    do_access(1'b1, 1'b0, 16'h0020, 16'h0, rd, err, lat, stray);
    tests++; if (lat !== 3 || rd !== 16'h0000) begin fails++;
      $display("FAIL rst_write_readback got lat=%0d data=%h expected 3 0000", lat, rd); end
    // fetch interrupted by reset during its RESP cycle
    freq = 1'b1; faddr = 16'h0004;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; freq = 1'b0;
    seen = fack1;
    @(negedge clock);
    seen = seen | fack1;
    $display("[TB] F RD addr=0004 aborted in RESP by reset, ack_seen=%0d", seen);
    tests++; if (seen !== 1'b0 || ferr1 !== 1'b0) begin fails++;
      $display("FAIL rst_resp_noack got ack=%b err=%b expected 0 0", seen, ferr1); end
  endtask

  initial begin
    tests = 0; fails = 0; mwe_cnt = 0;
    reset = 1'b1; freq = 1'b0; dreq = 1'b0; dwe = 1'b0; faultclr = 1'b0;
    faddr = 16'h0; daddr = 16'h0; dwdata = 16'h0;
    for (int i = 0; i < 256; i++) begin mem1[i] = 16'h0; mem0[i] = 16'h0; end
    mem1[4] = 16'h1234;
    mem0[4] = 16'h1234;
    test_reset();
    test_fair();
    test_fetch();
    test_write_read();
    test_oob();
    test_clr_capture();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
